// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM for an MM:SS stopwatch / countdown timer.
// Produces the count tick for the four-digit chain, steers validated manual
// digit loads, and detects countdown expiry from the datapath zero flag.
// Optional alarm hold in DONE is built only when STOPWATCH_CTRL_ALARM_EN is
// defined; otherwise DONE lasts one cycle and alarm is tied low.
//
// Pulse semantics: cnt_en, cnt_clr, load_sel and err are registered strobes,
// high for exactly one clock on the edge after the causing input; the digit
// chain must act on every cycle they are high (there is no back-pressure).
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       mode,
  input  logic       set,
  input  logic       set_next,
  input  logic       set_load,
  input  logic [3:0] value,
  input  logic       all_zero,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       cnt_mode,
  output logic [3:0] load_sel,
  output logic [3:0] load_value,
  output logic [1:0] digit_sel,
  output logic       err,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_SET   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          cnt_mode_q, cnt_mode_d;
  logic [3:0]    load_sel_q, load_sel_d;
  logic [3:0]    load_value_q, load_value_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic          err_q, err_d;
  // high in the cycle after cnt_en, when the digit chain has absorbed the tick
  logic          tick_seen_q, tick_seen_d;
  logic          wrap;
  logic [3:0]    digit_limit;

  assign wrap        = (presc_q == PRESC_MAX);
  assign digit_limit = digit_sel_q[0] ? 4'd5 : 4'd9;

`ifdef STOPWATCH_CTRL_ALARM_EN
  localparam int AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  logic          alarm_q, alarm_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
`endif

  // Next-state and next-output logic; clear overrides everything else.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_en_d     = 1'b0;
    cnt_clr_d    = 1'b0;
    cnt_mode_d   = cnt_mode_q;
    load_sel_d   = 4'b0000;
    load_value_d = 4'd0;
    digit_sel_d  = digit_sel_q;
    err_d        = 1'b0;
    tick_seen_d  = 1'b0;
    if (btn_clear) begin
      cnt_clr_d   = 1'b1;
      state_d     = S_IDLE;
      presc_d     = '0;
      digit_sel_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (btn_start) begin
            if (!mode && all_zero) begin
              err_d = 1'b1;
            end else begin
              state_d    = S_RUN;
              cnt_mode_d = mode;
              presc_d    = '0;
            end
          end else if (set) begin
            state_d     = S_SET;
            digit_sel_d = 2'd0;
          end
        end
        S_RUN: begin
          presc_d     = wrap ? '0 : presc_q + PW'(1);
          cnt_en_d    = wrap;
          tick_seen_d = cnt_en_q;
          if (tick_seen_q && !cnt_mode_q && all_zero) begin
            state_d  = S_DONE;
            presc_d  = '0;
            cnt_en_d = 1'b0;
          end else if (btn_start) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (btn_start) begin
            state_d = S_RUN;
          end else if (set) begin
            state_d     = S_SET;
            digit_sel_d = 2'd0;
          end
        end
        S_SET: begin
          if (set_load && set) begin
            if (value <= digit_limit) begin
              load_sel_d   = 4'b0001 << digit_sel_q;
              load_value_d = value;
            end else begin
              err_d = 1'b1;
            end
          end
          if (btn_start) begin
            err_d = 1'b1;
          end
          if (set_next) begin
            digit_sel_d = digit_sel_q + 2'd1;
          end
          if (!set) begin
            state_d = S_IDLE;
          end
        end
        S_DONE: begin
`ifdef STOPWATCH_CTRL_ALARM_EN
          presc_d = wrap ? '0 : presc_q + PW'(1);
          if (btn_start || (wrap && alarm_cnt_q == ALARM_LAST)) begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef STOPWATCH_CTRL_ALARM_EN
  // Alarm follows DONE occupancy; the tick counter runs only while in DONE.
  always_comb begin
    alarm_d     = (state_d == S_DONE);
    alarm_cnt_d = '0;
    if (state_q == S_DONE) begin
      alarm_cnt_d = wrap ? alarm_cnt_q + AW'(1) : alarm_cnt_q;
    end
  end

  // Alarm registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      cnt_mode_q   <= 1'b1;
      load_sel_q   <= 4'b0000;
      load_value_q <= 4'd0;
      digit_sel_q  <= 2'd0;
      err_q        <= 1'b0;
      tick_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      cnt_mode_q   <= cnt_mode_d;
      load_sel_q   <= load_sel_d;
      load_value_q <= load_value_d;
      digit_sel_q  <= digit_sel_d;
      err_q        <= err_d;
      tick_seen_q  <= tick_seen_d;
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign cnt_mode   = cnt_mode_q;
  assign load_sel   = load_sel_q;
  assign load_value = load_value_q;
  assign digit_sel  = digit_sel_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV = 4, ALARM_TICKS = 2.
// Pulse outputs (cnt_en, cnt_clr, load_sel, err) are matched against an
// expected-event queue tagged with the clock edge they must appear on;
// levels (state, cnt_mode, digit_sel, alarm) are checked directly.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_clear, mode, set, set_next, set_load, all_zero;
  logic [3:0] value;
  logic       cnt_en, cnt_clr, cnt_mode, err, alarm;
  logic [3:0] load_sel, load_value;
  logic [1:0] digit_sel;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // expected event: {edge[15:0], cnt_en, cnt_clr, load_sel[3:0], load_value[3:0], err}
  logic [26:0] exp_q[$];

  stopwatch_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear),
    .mode(mode), .set(set), .set_next(set_next), .set_load(set_load),
    .value(value), .all_zero(all_zero), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .cnt_mode(cnt_mode), .load_sel(load_sel), .load_value(load_value),
    .digit_sel(digit_sel), .err(err), .alarm(alarm), .state(state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int at, input logic en, input logic clr,
                         input logic [3:0] ls, input logic [3:0] lv, input logic e);
    exp_q.push_back({at[15:0], en, clr, ls, lv, e});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [26:0] act;
    logic [26:0] expv;
    if (!reset && (cnt_en || cnt_clr || err || (load_sel != 4'b0000))) begin
      act = {cyc[15:0], cnt_en, cnt_clr, load_sel, load_value, err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got edge=%0d en=%b clr=%b ls=%b lv=%0d err=%b, expected none",
                 cyc, cnt_en, cnt_clr, load_sel, load_value, err);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL event: got edge=%0d en=%b clr=%b ls=%b lv=%0d err=%b, expected edge=%0d en=%b clr=%b ls=%b lv=%0d err=%b",
                   act[26:11], act[10], act[9], act[8:5], act[4:1], act[0],
                   expv[26:11], expv[10], expv[9], expv[8:5], expv[4:1], expv[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
  endtask

  // one SET-state action; exp_ls/exp_err are the hand-computed responses
  task automatic set_act(input logic nxt, input logic ld, input logic [3:0] val,
                         input logic [3:0] exp_ls, input logic exp_err);
    if (exp_ls != 4'b0000 || exp_err)
      push_ev(cyc + 1, 1'b0, 1'b0, exp_ls, (exp_ls != 4'b0000) ? val : 4'd0, exp_err);
    set_next = nxt;
    set_load = ld;
    value    = val;
    step();
    set_next = 1'b0;
    set_load = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},     state,      0);
    chk({tag, "_cnt_mode"},  cnt_mode,   1);
    chk({tag, "_digit_sel"}, digit_sel,  0);
    chk({tag, "_cnt_en"},    cnt_en,     0);
    chk({tag, "_cnt_clr"},   cnt_clr,    0);
    chk({tag, "_load_sel"},  load_sel,   0);
    chk({tag, "_load_val"},  load_value, 0);
    chk({tag, "_err"},       err,        0);
    chk({tag, "_alarm"},     alarm,      0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int r;
    int e;
    reset = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; mode = 1'b1; set = 1'b0;
    set_next = 1'b0; set_load = 1'b0; value = 4'd0; all_zero = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk_reset_vals("reset");

    // up-count: ticks 4, 8, 12 edges after the start edge
    mode = 1'b1;
    press_start();
    s = cyc;
    chk("up_state_run", state, 1);
    chk("up_cnt_mode", cnt_mode, 1);
    push_ev(s + 4,  1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    push_ev(s + 8,  1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    push_ev(s + 12, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);

    // pause two clocks after the tick at s+12, hold 10, resume
    wait_until(s + 13);
    press_start();
    chk("pause_state", state, 2);
    repeat (10) step();
    chk("pause_held_state", state, 2);
    press_start();
    r = cyc;
    chk("resume_state", state, 1);
    push_ev(r + 2, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);

    // clear wins over start in the same cycle
    wait_until(r + 3);
    push_ev(r + 4, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    step();
    btn_clear = 1'b0;
    btn_start = 1'b0;
    chk("clear_state", state, 0);
    step();
    chk("clear_no_pause", state, 0);

    // SET: digit entry and validation
    set = 1'b1;
    step();
    chk("set_state", state, 3);
    chk("set_digit0", digit_sel, 0);
    set_act(1'b1, 1'b0, 4'd0, 4'b0000, 1'b0);
    chk("set_digit1", digit_sel, 1);
    set_act(1'b0, 1'b1, 4'd7, 4'b0000, 1'b1);
    set_act(1'b0, 1'b1, 4'd5, 4'b0010, 1'b0);
    set_act(1'b1, 1'b1, 4'd3, 4'b0010, 1'b0);
    chk("set_next_load_digit", digit_sel, 2);
    set_act(1'b0, 1'b1, 4'd9, 4'b0100, 1'b0);
    set_act(1'b1, 1'b0, 4'd0, 4'b0000, 1'b0);
    chk("set_digit3", digit_sel, 3);
    set_act(1'b0, 1'b1, 4'd6, 4'b0000, 1'b1);
    set_act(1'b0, 1'b1, 4'd5, 4'b1000, 1'b0);
    set_act(1'b1, 1'b0, 4'd0, 4'b0000, 1'b0);
    chk("set_digit_wrap", digit_sel, 0);
    set_act(1'b0, 1'b1, 4'd9, 4'b0001, 1'b0);
    set_act(1'b0, 1'b1, 4'd10, 4'b0000, 1'b1);
    push_ev(cyc + 1, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    press_start();
    chk("set_start_ignored", state, 3);
    set = 1'b0;
    step();
    chk("set_exit_idle", state, 0);

    // countdown expiry
    mode = 1'b0;
    all_zero = 1'b0;
    press_start();
    s = cyc;
    chk("down_cnt_mode", cnt_mode, 0);
    push_ev(s + 4, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    wait_until(s + 4);
    all_zero = 1'b1;
    step();
    chk("down_still_run", state, 1);
    step();
    e = cyc;
    chk("done_entry_edge", e, s + 6);
`ifdef STOPWATCH_CTRL_ALARM_EN
    for (int i = 0; i < 8; i++) begin
      chk("done_state", state, 4);
      chk("done_alarm", alarm, 1);
      step();
    end
    chk("done_exit_state", state, 0);
    chk("done_exit_alarm", alarm, 0);
`else
    chk("done_state", state, 4);
    chk("done_alarm_off", alarm, 0);
    step();
    chk("done_exit_state", state, 0);
    chk("done_exit_alarm", alarm, 0);
`endif

    // countdown start while already at zero is rejected
    push_ev(cyc + 1, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    press_start();
    chk("zero_start_state", state, 0);
    all_zero = 1'b0;

    // reset mid-RUN, then the prescaler restarts from zero
    mode = 1'b0;
    press_start();
    s = cyc;
    push_ev(s + 4, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    wait_until(s + 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("midrun");
    mode = 1'b1;
    press_start();
    s = cyc;
    push_ev(s + 4, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    push_ev(s + 8, 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    wait_until(s + 9);
    push_ev(cyc + 1, 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    repeat (6) step();
    chk("final_state", state, 0);
    chk("events_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

- Control FSM for the stopwatch/countdown timer; sequences the four MM:SS digit counters.
- Digit 0 is sec units (0–9), digit 1 is sec tens (0–5), digit 2 is min units (0–9), digit 3 is min tens (0–5).
- Divides the system clock into a one-cycle count tick and gates it by run state.
- Validates and steers manual digit loads, and detects countdown expiry from the datapath's zero flag.

## Interface
- `TICK_DIV`, 50_000_000: system clocks per count tick (≥2).
- `ALARM_TICKS`, 5: count ticks the alarm stays high after countdown expiry.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; all state to reset values.
- `btn_start` in 1: one-cycle pulse; start/pause toggle.
- `btn_clear` in 1: one-cycle pulse; clear time, return to IDLE.
- `mode` in 1: 1 = count up, 0 = count down; sampled only on IDLE→RUN.
- `set` in 1: level; request digit-entry state.
- `set_next` in 1: pulse; advance selected digit 0→1→2→3→0.
- `set_load` in 1: pulse; load `value` into selected digit.
- `value` in 4: digit value for load.
- `all_zero` in 1: datapath flag, all four digits are 0.
- `cnt_en` out 1: one-cycle count enable to digit chain.
- `cnt_clr` out 1: one-cycle clear to digit chain.
- `cnt_mode` out 1: latched direction to digit chain.
- `load_sel` out 4: one-hot digit load strobe.
- `load_value` out 4: data accompanying `load_sel`.
- `digit_sel` out 2: currently selected digit in SET.
- `err` out 1: one-cycle pulse on a rejected action.
- `alarm` out 1: countdown-expired indicator.
- `state` out 3: IDLE=0, RUN=1, PAUSE=2, SET=3, DONE=4.

## Operation
- **Reset values:**
  - `state` = IDLE; `cnt_mode` = 1; `digit_sel` = 0; prescaler = 0.
  - `cnt_en`, `cnt_clr`, `load_sel`, `load_value`, `err`, `alarm` = 0.
- **IDLE:**
  - `btn_start` → RUN, latch `cnt_mode` = `mode`, prescaler = 0.
  - Exception: `mode` = 0 with `all_zero` = 1 → stay IDLE, `err` pulse.
  - `set` = 1 → SET, `digit_sel` = 0.
- **RUN:**
  - Prescaler counts 0..`TICK_DIV`-1; on wrap to 0, `cnt_en` = 1 for one cycle.
  - `btn_start` → PAUSE.
  - `cnt_mode` = 0 and `all_zero` = 1 (sampled the cycle after a tick) → DONE.
  - `set` is ignored.
- **PAUSE:**
  - Prescaler held, not cleared.
  - `btn_start` → RUN, resuming at the held prescaler value; `cnt_mode` is kept.
  - `set` = 1 → SET.
- **SET:**
  - `set_next` advances `digit_sel` mod 4.
  - On `set_load`, the legal limit is 9 for digits 0/2 and 5 for digits 1/3.
    - Legal: `load_sel` = one-hot(`digit_sel`) and `load_value` = `value` for one cycle.
    - Illegal: no load, `err` pulse.
  - `set` = 0 → IDLE.
  - `btn_start` is ignored, with an `err` pulse.
- **DONE:**
  - `alarm` = 1 and `cnt_en` = 0.
  - After `ALARM_TICKS` internal ticks → IDLE with `alarm` = 0.
  - `btn_start` acknowledges: → IDLE immediately.
- **Clear:**
  - `btn_clear` in any non-reset state → `cnt_clr` one cycle, state IDLE, prescaler = 0, `alarm` = 0, `digit_sel` = 0.
  - Clear takes priority over every other input in the same cycle.
- **Simultaneous events:**
  - `set_next` and `set_load` in the same cycle: load uses the old `digit_sel`, then it advances.
  - `btn_start` and a tick in the same cycle (RUN): the tick's `cnt_en` is still issued, then the block enters PAUSE.
- **Arithmetic:** prescaler width is clog2(`TICK_DIV`) and wraps exactly at `TICK_DIV`-1. The alarm counter is clog2(`ALARM_TICKS`+1) bits.

## Timing
- All outputs are registered; every response appears on the clock edge after the causing input.
- `cnt_en` is asserted first on the `TICK_DIV`-th clock after RUN entry from IDLE, then every `TICK_DIV` clocks.
- PAUSE→RUN: the next `cnt_en` comes `TICK_DIV` minus the held count clocks later.
- `cnt_clr`, `load_sel` and `err` are exactly one cycle wide. `load_sel` is never asserted outside SET.
- `reset` overrides everything on the same edge, including mid-RUN and mid-DONE.

## Configuration
- Macro: `STOPWATCH_CTRL_ALARM_EN`.
- **Defined:** DONE behaves as above, and `alarm` holds for `ALARM_TICKS` ticks or until `btn_start`.
- **Undefined:**
  - The alarm counter is not built and `alarm` is tied 0.
  - DONE lasts exactly one cycle, then goes to IDLE.
  - `ALARM_TICKS` is unused.

## Test plan
Bench uses `TICK_DIV` = 4 and `ALARM_TICKS` = 2.

- **Up-count ticks:** `reset`, `mode` = 1, `btn_start` → `state` = 1, `cnt_mode` = 1, `cnt_en` high on cycles 4, 8, 12 after start.
- **Pause/resume:** pause 2 clocks after a tick, wait 10, resume → first `cnt_en` 2 clocks after resume.
- **SET loads:**
  - Digit 1 with `value` = 7 → `err` = 1, no `load_sel`.
  - Digit 1 with `value` = 5 → `load_sel` = 4'b0010, `load_value` = 5.
  - Digit 0 with 9 → `load_sel` = 4'b0001.
- **Countdown expiry:**
  - `mode` = 0, start, force `all_zero` after a tick → DONE, `alarm` = 1 for 8 clocks (2 ticks), then IDLE.
  - Without the macro: DONE lasts one cycle and `alarm` stays 0.
- **Clear priority:** `btn_clear` together with `btn_start` in RUN → `cnt_clr` one cycle, `state` = 0, no PAUSE.
- **Reset mid-RUN:**
  - Assert `reset` mid-RUN → all outputs at reset values next edge, and the prescaler restarts after a new start.
  - Countdown start with `all_zero` = 1 → `err` pulse, stays IDLE.
